// File: rtl/time_param_programmer.sv
// Buffers host time-parameter writes in a small FIFO. Each write is replayed to the traffic
// controller as a setup / reprogram-pulse / hold sequence that is slow enough for its synchronizer.
module time_param_programmer #(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [1:0]       wr_selector,
    input  logic [3:0]       wr_value,
    output logic [1:0]       extTimeSelector,
    output logic [3:0]       extTimeValue,
    output logic             reprogram,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int unsigned MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StPulse, StHold} state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [1:0]         sel_d;
    logic [3:0]         val_d;
    logic               rep_d, done_d;
    logic [5:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_d;
    logic               push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign wr_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign busy     = (state_q != StIdle);
    assign push     = wr_valid && wr_ready;
    assign pop      = (state_q == StIdle) && (fifo_count != '0);

    always_comb begin
        count_d = fifo_count;
        if (push && !pop) begin
            count_d = fifo_count + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = fifo_count - CNT_W'(1);
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {wr_selector, wr_value};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            fifo_count <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        sel_d   = extTimeSelector;
        val_d   = extTimeValue;
        rep_d   = reprogram;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    {sel_d, val_d} = mem[rd_ptr_q];
                    tmr_d          = TMR_W'(SETUP_CYCLES - 1);
                    state_d        = StSetup;
                end
            end
            StSetup: begin
                if (tmr_q == '0) begin
                    rep_d   = 1'b1;
                    tmr_d   = TMR_W'(PULSE_CYCLES - 1);
                    state_d = StPulse;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StPulse: begin
                if (tmr_q == '0) begin
                    rep_d   = 1'b0;
                    tmr_d   = TMR_W'(HOLD_CYCLES - 1);
                    state_d = StHold;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StHold: begin
                if (tmr_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            tmr_q           <= '0;
            extTimeSelector <= '0;
            extTimeValue    <= '0;
            reprogram       <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            tmr_q           <= tmr_d;
            extTimeSelector <= sel_d;
            extTimeValue    <= val_d;
            reprogram       <= rep_d;
            done            <= done_d;
        end
    end

endmodule

// File: tb/tb_time_param_programmer.sv
// Bench for time_param_programmer: a timeline model (age since pop + request queue) predicts
// every output of a default instance and a minimal-parameter instance each cycle.
module tb_time_param_programmer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       v0, v1;
    logic [1:0] s0, s1, es0, es1;
    logic [3:0] d0, d1, ev0, ev1;
    logic       rp0, rp1, bz0, bz1, dn0, dn1, rdy0, rdy1;
    logic [2:0] cnt0;
    logic [0:0] cnt1;

    time_param_programmer dut0 (
        .clk(clk), .reset(reset), .wr_valid(v0), .wr_ready(rdy0), .wr_selector(s0),
        .wr_value(d0), .extTimeSelector(es0), .extTimeValue(ev0), .reprogram(rp0),
        .busy(bz0), .done(dn0), .fifo_count(cnt0)
    );

    time_param_programmer #(
        .SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1), .FIFO_DEPTH(1)
    ) dut1 (
        .clk(clk), .reset(reset), .wr_valid(v1), .wr_ready(rdy1), .wr_selector(s1),
        .wr_value(d1), .extTimeSelector(es1), .extTimeValue(ev1), .reprogram(rp1),
        .busy(bz1), .done(dn1), .fifo_count(cnt1)
    );

    wire [12:0] obs0 = {es0, ev0, rp0, bz0, dn0, cnt0, rdy0};
    wire [12:0] obs1 = {es1, ev1, rp1, bz1, dn1, 2'b00, cnt1, rdy1};

    int tests = 0;
    int fails = 0;

    // Model: per instance, a queue of requests and the age (edges) since the last pop.
    int         ms[2] = '{2, 1};
    int         mp[2] = '{4, 1};
    int         mh[2] = '{2, 1};
    int         md[2] = '{4, 1};
    logic [5:0] mbuf[2][8];
    int         msize[2], mhead[2], mage[2];
    bit         mact[2];
    logic [5:0] mout[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            msize[k] = 0; mhead[k] = 0; mage[k] = 0; mact[k] = 0; mout[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input bit v, input logic [5:0] req);
        int  tot;
        bit  can_pop, do_push;
        tot     = ms[k] + mp[k] + mh[k];
        can_pop = (!mact[k] || mage[k] >= tot) && msize[k] > 0;
        do_push = v && (msize[k] < md[k]);
        if (mact[k] && mage[k] < 1000) mage[k]++;
        if (can_pop) begin
            mout[k]  = mbuf[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % md[k];
            msize[k]--;
            mact[k]  = 1;
            mage[k]  = 0;
        end
        if (do_push) begin
            mbuf[k][(mhead[k] + msize[k]) % md[k]] = req;
            msize[k]++;
        end
    endtask

    function automatic logic [12:0] exp_vec(input int k);
        int a, tot;
        bit rp, bz, dn;
        a   = mage[k];
        tot = ms[k] + mp[k] + mh[k];
        rp  = mact[k] && a >= ms[k] && a < ms[k] + mp[k];
        bz  = mact[k] && a < tot;
        dn  = mact[k] && a == tot;
        return {mout[k], rp, bz, dn, 3'(msize[k]), (msize[k] < md[k])};
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else begin
                model_step(0, v0, {s0, d0});
                model_step(1, v1, {s1, d1});
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; v0 = 0; v1 = 0; s0 = 0; d0 = 0; s1 = 0; d1 = 0;
        repeat (2) @(negedge clk);
        tests++;
        if (obs0 !== 13'h001) begin
            fails++; $display("FAIL reset0 got=%h want=%h", obs0, 13'h001);
        end
        tests++;
        if (obs1 !== 13'h001) begin
            fails++; $display("FAIL reset1 got=%h want=%h", obs1, 13'h001);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        v0 = 1; s0 = 2'd2; d0 = 4'd9;
        @(negedge clk);
        v0 = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            tests++;
            if (obs0 !== exp_vec(0)) begin
                fails++; $display("FAIL single c%0d got=%h want=%h", i, obs0, exp_vec(0));
            end
            if (i == 1 || i == 3 || i == 7 || i == 9 || i == 10) begin
                tests++;
                if ((i == 1 && {es0, ev0} !== {2'd2, 4'd9}) || (i == 3 && rp0 !== 1'b1) ||
                    (i == 7 && rp0 !== 1'b0) || (i == 9 && dn0 !== 1'b1) ||
                    (i == 10 && (bz0 !== 1'b0 || dn0 !== 1'b0))) begin
                    fails++;
                    $display("FAIL single_time c%0d got sel=%0d val=%0d rp=%b dn=%b bz=%b", i,
                             es0, ev0, rp0, dn0, bz0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] reqs[3];
        int rise[3];
        int nrise = 0, ndone = 0;
        bit prev = 0;
        reqs[0] = {2'd0, 4'd5}; reqs[1] = {2'd1, 4'd7}; reqs[2] = {2'd3, 4'd12};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tests++;
            if (obs0 !== exp_vec(0)) begin
                fails++; $display("FAIL b2b c%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (rp0 && !prev && nrise < 3) begin rise[nrise] = c; nrise++; end
            prev = rp0;
            if (dn0) ndone++;
            if (c < 3) begin v0 = 1; {s0, d0} = reqs[c]; end
            else v0 = 0;
        end
        tests++;
        if (ndone != 3 || nrise != 3) begin
            fails++; $display("FAIL b2b_counts done=%0d rises=%0d want 3/3", ndone, nrise);
        end else begin
            tests++;
            if (rise[1] - rise[0] != 9 || rise[2] - rise[1] != 9) begin
                fails++; $display("FAIL b2b_period got %0d,%0d want 9,9",
                                  rise[1] - rise[0], rise[2] - rise[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] reqs[6];
        int idx = 0;
        bit saw_full = 0, acc;
        int base = $urandom_range(0, 15);
        for (int i = 0; i < 6; i++) reqs[i] = {2'($urandom_range(0, 3)), 4'((base + i) % 16)};
        @(negedge clk);
        v0 = 1; {s0, d0} = reqs[0];
        for (int c = 0; c < 300 && idx < 6; c++) begin
            acc = rdy0;
            @(negedge clk);
            tests++;
            if (obs0 !== exp_vec(0)) begin
                fails++; $display("FAIL bp c%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (!rdy0) saw_full = 1;
            if (acc) begin
                idx++;
                if (idx < 6) {s0, d0} = reqs[idx];
                else v0 = 0;
            end
        end
        v0 = 0;
        tests++;
        if (idx != 6 || !saw_full) begin
            fails++; $display("FAIL bp_accept got accepted=%0d full=%b want 6/1", idx, saw_full);
        end
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            tests++;
            if (obs0 !== exp_vec(0)) begin
                fails++; $display("FAIL bp_drain c%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int nrp = 0, ndone = 0;
        for (int c = 0; c < 40 && nrp < 2; c++) begin
            @(negedge clk);
            tests++;
            if (obs0 !== exp_vec(0)) begin
                fails++; $display("FAIL rst_pre c%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (rp0) nrp++;
            v0 = (c < 3); {s0, d0} = {2'(c), 4'(c + 3)};
        end
        tests++;
        if (nrp != 2 || cnt0 !== 3'd2) begin
            fails++; $display("FAIL rst_setup got pulse_cycles=%0d count=%0d want 2/2", nrp, cnt0);
        end
        v0 = 0;
        reset = 1'b1;
        #1;
        tests++;
        if ({es0, ev0, rp0, bz0, dn0, cnt0} !== 12'h000) begin
            fails++; $display("FAIL rst_async got sel=%0d val=%0d rp=%b bz=%b cnt=%0d want 0",
                              es0, ev0, rp0, bz0, cnt0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests++;
            if (obs0 !== exp_vec(0)) begin
                fails++; $display("FAIL rst_post c%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (dn0 || bz0 || rp0) ndone++;
        end
        tests++;
        if (ndone != 0) begin
            fails++; $display("FAIL rst_quiet got active_cycles=%0d want 0", ndone);
        end
    endtask

    task automatic test_push_pop_same();
        bit found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            tests++;
            if (obs0 !== exp_vec(0)) begin
                fails++; $display("FAIL pp_pre c%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
            if (c > 3 && dn0) found = 1;
            v0 = (c < 3); {s0, d0} = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        end
        tests++;
        if (!found || cnt0 !== 3'd2) begin
            fails++; $display("FAIL pp_wait got done_seen=%b count=%0d want 1/2", found, cnt0);
        end
        v0 = 1; {s0, d0} = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        @(negedge clk);
        v0 = 0;
        tests++;
        if (cnt0 !== 3'd2 || bz0 !== 1'b1) begin
            fails++; $display("FAIL pp_count got count=%0d busy=%b want 2/1", cnt0, bz0);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tests++;
            if (obs0 !== exp_vec(0)) begin
                fails++; $display("FAIL pp_drain c%0d got=%h want=%h", c, obs0, exp_vec(0));
            end
        end
    endtask

    task automatic test_small_params();
        int last_rise = -1;
        bit prev = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            tests++;
            if (obs1 !== exp_vec(1)) begin
                fails++; $display("FAIL small c%0d got=%h want=%h", c, obs1, exp_vec(1));
            end
            if (rp1 && prev) begin
                tests++; fails++;
                $display("FAIL small_width c%0d got reprogram high 2 cycles want 1", c);
            end
            if (rp1 && !prev) begin
                if (last_rise >= 0 && c < 24) begin
                    tests++;
                    if (c - last_rise != 4) begin
                        fails++; $display("FAIL small_period got %0d want 4", c - last_rise);
                    end
                end
                last_rise = c;
            end
            prev = rp1;
            v1 = (c < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            {s1, d1} = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        end
        v1 = 0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_pulse();
        test_push_pop_same();
        test_small_params();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/time_param_programmer.md
Name: time_param_programmer

Overview:
- Host-side writer for the traffic controller's external reprogramming interface; drives `extTimeSelector`, `extTimeValue` and `reprogram` into the controller.
- Accepts time-parameter write requests over a valid/ready handshake and buffers them in a small FIFO.
- Replays each request as a timed sequence: setup, then a `reprogram` pulse, then hold. Each phase is long enough to pass the controller's input synchronizer.
- Sits between a host, test panel or UART command decoder and the controller top.

Parameters:
- SETUP_CYCLES, 2, cycles the selector/value are stable before `reprogram` rises (>=1)
- PULSE_CYCLES, 4, cycles `reprogram` is held high (>=1)
- HOLD_CYCLES, 2, cycles the selector/value stay stable after `reprogram` falls (>=1)
- FIFO_DEPTH, 4, number of buffered write requests (>=1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- wr_valid  input  1  host write request valid
- wr_ready  output  1  FIFO can accept a request
- wr_selector  input  2  interval address to reprogram
- wr_value  input  4  new time value for that interval
- extTimeSelector  output  2  to controller selector input
- extTimeValue  output  4  to controller reprogram value input
- reprogram  output  1  to controller reprogram input
- busy  output  1  high while state != IDLE
- done  output  1  one-cycle pulse per completed write
- fifo_count  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset is asynchronous. It forces:
  - state=IDLE, FIFO empty, fifo_count=0
  - extTimeSelector=0, extTimeValue=0, reprogram=0, done=0, busy=0
  - wr_ready=1
- Reset mid-sequence aborts the write in progress and flushes all queued requests.
- wr_ready = (fifo_count < FIFO_DEPTH), combinational from the registered count.
- Push occurs when wr_valid and wr_ready are both high at a rising edge. {wr_selector, wr_value} is stored.
- wr_valid while wr_ready=0 is ignored: no state change and no error flag.
- The FIFO is circular. Pointers wrap modulo FIFO_DEPTH. Order is strictly FIFO.
- FSM states: IDLE, SETUP, PULSE, HOLD. One down-counter is loaded on each state entry.
- IDLE:
  - If fifo_count>0 at an edge: pop the head entry, register it onto extTimeSelector/extTimeValue, load the counter with SETUP_CYCLES, and go to SETUP.
  - Otherwise stay in IDLE. extTimeSelector/extTimeValue keep their last values.
- SETUP: reprogram=0. When the counter expires, set reprogram=1 (registered) and go to PULSE.
- PULSE: reprogram=1 for exactly PULSE_CYCLES cycles. Then reprogram=0 and go to HOLD.
- HOLD: lasts HOLD_CYCLES cycles. On exit, done=1 for exactly one cycle and the FSM returns to IDLE.
- A pop may occur at the same edge that ends the done cycle, giving back-to-back sequences.
- Timing, taking E1 as the edge where the pop occurs:
  - Selector/value are valid from E1.
  - reprogram is high from E1+SETUP_CYCLES to E1+SETUP_CYCLES+PULSE_CYCLES.
  - done is high in the cycle starting at E1+SETUP+PULSE+HOLD.
  - Next pop is at E1+SETUP+PULSE+HOLD+1. With defaults this is a 9-cycle period per write.
- extTimeSelector/extTimeValue never change while state is SETUP, PULSE or HOLD.
- Push and pop in the same cycle are legal: fifo_count is unchanged and both pointers advance.
- Push into an empty FIFO is first popped at the following edge. A request accepted at edge E0 pops at E1 = E0+1 when the FSM is idle.
- All outputs are registered except wr_ready and busy, which are decoded from registers.
- No glitches on reprogram.

Test Plan:
1. Reset, then one write (sel=2, val=9) → after E0, pop at E0+1; ext outputs = 2/9; reprogram high for cycles E0+3..E0+6; done pulses at E0+9; busy low at E0+10.
2. Three back-to-back writes (sel 0/1/3, val 5/7/12) → three sequences in order; reprogram rising edges 9 cycles apart; exactly 3 done pulses; ext values stable around each pulse.
3. Hold wr_valid high with 6 distinct requests while the FSM is busy:
   - wr_ready drops once fifo_count=4 (request 1 is already popped).
   - Blocked requests are dropped only if wr_valid is released; held requests are taken when space frees.
   - All accepted writes emerge in order.
4. Assert reset for 1 cycle in the 2nd cycle of PULSE with 2 entries queued → reprogram=0 immediately (asynchronous); fifo_count=0; ext outputs=0; no done pulse; no further sequence.
5. Push in the same cycle as a pop with fifo_count=2 → fifo_count stays 2; the entry appears at the correct order position.
6. Non-default parameters SETUP=1, PULSE=1, HOLD=1, DEPTH=1 → 4-cycle period; wr_ready toggles correctly; reprogram is exactly a 1-cycle pulse.
